// File: rtl/chacha_ibuf_if.sv
// chacha_ibuf_if
//   Byte-stream bundle between the ingress source, the frame buffer and the
//   ChaCha20 stage.
//   Ingress: dat_i[7:0], val_i, sof_i, eof_i (no backpressure).
//   Egress : dat_o[7:0], val_o, sof_o, eof_o, plus cts from the cipher.
//   slave  : the buffer side (consumes ingress and cts, drives egress).
//   master : the environment side (drives ingress and cts, consumes egress).
interface chacha_ibuf_if;
  logic [7:0] dat_i;
  logic       val_i;
  logic       sof_i;
  logic       eof_i;
  logic       cts;
  logic [7:0] dat_o;
  logic       val_o;
  logic       sof_o;
  logic       eof_o;

  modport slave (
    input  dat_i, val_i, sof_i, eof_i, cts,
    output dat_o, val_o, sof_o, eof_o
  );

  modport master (
    output dat_i, val_i, sof_i, eof_i, cts,
    input  dat_o, val_o, sof_o, eof_o
  );
endinterface

// File: rtl/chacha_ibuf.sv
// chacha_ibuf
//   Store-and-forward ingress frame buffer in front of the ChaCha20 stage.
//   Whole frames are held in a byte RAM and released as gap-free bursts once
//   the cipher signals clear-to-send; overflowing or aborted frames are
//   discarded whole.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - chacha_ibuf_if.slave: ingress bytes/framing, cts, egress bytes
//   ovf  - one-cycle pulse when a frame is dropped
//   frm  - number of committed frames waiting
//
// Read-side FSM
//   state  | meaning
//   IDLE   | waiting for a committed frame and cts
//   SEND   | one RAM read per cycle; leaves when the eof entry is read
//   LAST   | final byte on the output register, frame count decrements
module chacha_ibuf #(
  parameter  int DEPTH = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  chacha_ibuf_if.slave        bus,
  output logic                ovf,
  output logic [AW:0]         frm
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_LAST} state_t;

  // RAM entries are {eof, dat}
  logic [8:0]    mem [DEPTH];

  logic [AW:0]   wp_q, wp_d, cp_q, cp_d, rp_q, rp_d, frm_q, frm_d;
  logic          open_q, open_d, ovf_q, ovf_d;
  logic          first_q, first_d;
  state_t        state_q, state_d;

  logic [7:0]    dat_o_q, dat_o_d;
  logic          val_o_q, val_o_d, sof_o_q, sof_o_d, eof_o_q, eof_o_d;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_data;
  logic          commit;
  logic [AW:0]   used_wp, used_cp;
  logic [8:0]    rd_word;
  logic          rd_en, rel_frm;

  // Occupancy seen by a continuing byte (wp) and by a new frame start (cp);
  // a new sof always restarts from cp since any open frame is abandoned.
  assign used_wp = wp_q - rp_q;
  assign used_cp = cp_q - rp_q;
  assign wr_data = {bus.eof_i, bus.dat_i};

  // ---------------- write side ----------------
  always_comb begin
    wp_d    = wp_q;
    cp_d    = cp_q;
    open_d  = open_q;
    ovf_d   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = wp_q[AW-1:0];
    commit  = 1'b0;
    if (bus.val_i) begin
      if (bus.sof_i) begin
        ovf_d = open_q;
        if (used_cp == FULL_LVL) begin
          wp_d   = cp_q;
          open_d = 1'b0;
          ovf_d  = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_addr = cp_q[AW-1:0];
          wp_d    = cp_q + ONE;
          open_d  = ~bus.eof_i;
          if (bus.eof_i) begin
            cp_d   = cp_q + ONE;
            commit = 1'b1;
          end
        end
      end else if (open_q) begin
        if (used_wp == FULL_LVL) begin
          wp_d   = cp_q;
          open_d = 1'b0;
          ovf_d  = 1'b1;
        end else begin
          wr_en = 1'b1;
          wp_d  = wp_q + ONE;
          if (bus.eof_i) begin
            cp_d   = wp_q + ONE;
            open_d = 1'b0;
            commit = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Combinational peek at the current entry lets SEND stop exactly on the
  // eof entry without over-reading; the data itself is registered below.
  assign rd_word = mem[rp_q[AW-1:0]];

  // ---------------- read FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---------------- read FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if ((frm_q != '0) && bus.cts) state_d = S_SEND;
      S_SEND:  if (rd_word[8]) state_d = S_LAST;
      S_LAST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- read FSM: outputs ----------------
  always_comb begin
    rd_en   = (state_q == S_SEND);
    rel_frm = (state_q == S_LAST);
    first_d = first_q;
    if (state_q == S_IDLE && state_d == S_SEND) first_d = 1'b1;
    else if (rd_en)                             first_d = 1'b0;
  end

  // ---------------- read datapath ----------------
  always_comb begin
    rp_d    = rd_en ? rp_q + ONE : rp_q;
    val_o_d = rd_en;
    sof_o_d = rd_en & first_q;
    eof_o_d = rd_en & rd_word[8];
    dat_o_d = rd_en ? rd_word[7:0] : 8'h00;
    case ({commit, rel_frm})
      2'b10:   frm_d = frm_q + ONE;
      2'b01:   frm_d = frm_q - ONE;
      default: frm_d = frm_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q    <= '0;
      cp_q    <= '0;
      rp_q    <= '0;
      frm_q   <= '0;
      open_q  <= 1'b0;
      ovf_q   <= 1'b0;
      first_q <= 1'b0;
      dat_o_q <= 8'h00;
      val_o_q <= 1'b0;
      sof_o_q <= 1'b0;
      eof_o_q <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      cp_q    <= cp_d;
      rp_q    <= rp_d;
      frm_q   <= frm_d;
      open_q  <= open_d;
      ovf_q   <= ovf_d;
      first_q <= first_d;
      dat_o_q <= dat_o_d;
      val_o_q <= val_o_d;
      sof_o_q <= sof_o_d;
      eof_o_q <= eof_o_d;
    end
  end

  assign bus.dat_o = dat_o_q;
  assign bus.val_o = val_o_q;
  assign bus.sof_o = sof_o_q;
  assign bus.eof_o = eof_o_q;
  assign ovf       = ovf_q;
  assign frm       = frm_q;

endmodule

// File: tb/tb_chacha_ibuf.sv
// Testbench for chacha_ibuf (DEPTH = 16). Expected output bytes are queued as
// frames are driven; a negedge monitor pops and compares on every val_o.
module tb_chacha_ibuf;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  chacha_ibuf_if bus ();
  logic          ovf;
  logic [AW:0]   frm;

  chacha_ibuf #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .ovf (ovf),
    .frm (frm)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   pops  = 0;
  int   ovf_cnt = 0;
  bit   lat_chk = 1'b0;
  int   lat_exp = 0;
  logic prev_eof = 1'b0;
  logic prev_ovf = 1'b0;
  logic [9:0] exp_q [$];   // {sof, eof, dat}

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (prev_eof) check("gap_after_eof", int'(bus.val_o), 0);
      if (bus.val_o) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got 0x%0h with no frame expected (cycle %0d)",
                   {bus.sof_o, bus.eof_o, bus.dat_o}, cyc);
        end else begin
          check("out_byte", int'({bus.sof_o, bus.eof_o, bus.dat_o}), int'(exp_q.pop_front()));
        end
        pops++;
        if (lat_chk && bus.sof_o) begin
          check("latency_cycle", cyc, lat_exp);
          lat_chk = 1'b0;
        end
      end
      if (ovf) begin
        ovf_cnt++;
        if (prev_ovf) check("ovf_width", 2, 1);
      end
    end
    prev_eof = bus.val_o & bus.eof_o;
    prev_ovf = ovf;
  end

  task automatic drive(bit v, bit s, bit e, logic [7:0] d);
    @(posedge clk);
    #1;
    bus.val_i = v;
    bus.sof_i = s;
    bus.eof_i = e;
    bus.dat_i = d;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic set_cts(bit c);
    @(posedge clk);
    #1 bus.cts = c;
  endtask

  // Drives a whole frame then one idle cycle; optionally queues its bytes and
  // arms the eof-to-first-byte latency check.
  task automatic send_frame(int len, logic [7:0] base, bit push, bit lat);
    logic [7:0] d;
    bit s, e;
    for (int i = 0; i < len; i++) begin
      d = base + 8'(i);
      s = (i == 0);
      e = (i == len - 1);
      drive(1'b1, s, e, d);
      if (push) exp_q.push_back({s, e, d});
      if (lat && e) begin
        lat_exp = cyc + 3;
        lat_chk = 1'b1;
      end
    end
    idle(1);
  endtask

  task automatic wait_drain(int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, p0, k;
    bus.val_i = 1'b0;
    bus.sof_i = 1'b0;
    bus.eof_i = 1'b0;
    bus.dat_i = 8'h00;
    bus.cts   = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_val_o", int'(bus.val_o), 0);
    check("rst_dat_o", int'(bus.dat_o), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_frm", int'(frm), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // single 5-byte frame, latency 3
    set_cts(1'b1);
    send_frame(5, 8'h01, 1'b1, 1'b1);
    @(negedge clk);
    check("t1_frm_after_commit", int'(frm), 1);
    wait_drain(40);
    idle(2);
    check("t1_frm_released", int'(frm), 0);

    // one-byte frame
    send_frame(1, 8'hAA, 1'b1, 1'b1);
    wait_drain(40);
    idle(2);
    check("t2_ovf_none", ovf_cnt, 0);

    // three frames held by cts = 0
    set_cts(1'b0);
    p0 = pops;
    send_frame(4, 8'h10, 1'b1, 1'b0);
    send_frame(7, 8'h20, 1'b1, 1'b0);
    send_frame(1, 8'h30, 1'b1, 1'b0);
    idle(3);
    @(negedge clk);
    check("t3_frm_held", int'(frm), 3);
    check("t3_no_output_held", pops - p0, 0);
    set_cts(1'b1);
    wait_drain(100);
    idle(3);
    check("t3_frm_released", int'(frm), 0);

    // overflow drop, then full-capacity frame across pointer wrap
    set_cts(1'b0);
    o0 = ovf_cnt;
    send_frame(10, 8'h40, 1'b1, 1'b0);
    send_frame(10, 8'h50, 1'b0, 1'b0);
    idle(3);
    @(negedge clk);
    check("t4_ovf_pulses", ovf_cnt - o0, 1);
    check("t4_frm_one", int'(frm), 1);
    set_cts(1'b1);
    wait_drain(60);
    idle(3);
    set_cts(1'b0);
    o0 = ovf_cnt;
    send_frame(16, 8'h60, 1'b1, 1'b0);
    idle(2);
    @(negedge clk);
    check("t4_full_frm", int'(frm), 1);
    check("t4_full_no_ovf", ovf_cnt - o0, 0);
    set_cts(1'b1);
    wait_drain(60);
    idle(3);
    check("t4_frm_released", int'(frm), 0);

    // sof inside an open frame aborts it; stray bytes ignored
    o0 = ovf_cnt;
    drive(1'b1, 1'b1, 1'b0, 8'h70);
    drive(1'b1, 1'b0, 1'b0, 8'h71);
    send_frame(4, 8'h80, 1'b1, 1'b0);
    idle(2);
    check("t5_abort_ovf", ovf_cnt - o0, 1);
    wait_drain(40);
    idle(3);
    o0 = ovf_cnt;
    p0 = pops;
    drive(1'b1, 1'b0, 1'b0, 8'h99);
    drive(1'b1, 1'b0, 1'b0, 8'h9B);
    drive(1'b1, 1'b0, 1'b1, 8'h9A);
    idle(6);
    check("t5_stray_no_ovf", ovf_cnt - o0, 0);
    check("t5_stray_no_output", pops - p0, 0);
    check("t5_stray_frm", int'(frm), 0);

    // reset in the middle of SEND
    p0 = pops;
    send_frame(12, 8'hB0, 1'b1, 1'b0);
    k = 0;
    while (pops < p0 + 3 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("t6_reached_send", int'(pops >= p0 + 3), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t6_val_o", int'(bus.val_o), 0);
    check("t6_sof_eof", int'({bus.sof_o, bus.eof_o}), 0);
    check("t6_dat_o", int'(bus.dat_o), 0);
    check("t6_ovf", int'(ovf), 0);
    check("t6_frm", int'(frm), 0);
    idle(2);
    send_frame(6, 8'hC0, 1'b1, 1'b1);
    wait_drain(40);
    idle(3);
    check("t6_frm_after", int'(frm), 0);
    check("latency_armed_left", int'(lat_chk), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/chacha_ibuf.md
# chacha_ibuf

Store-and-forward ingress frame buffer placed directly upstream of the ChaCha20 stream stage. Accepts a byte stream with sof/eof framing and no backpressure, holds complete frames in an internal byte RAM, and releases each committed frame to the cipher as a gap-free burst once the cipher signals clear-to-send. Frames that overflow the buffer or are malformed are discarded whole, so the cipher only ever sees complete frames.

## Interface
- DEPTH, 2048: byte capacity of the buffer; power of two, ≥ 16.
- AW, $clog2(DEPTH): address width (derived, not overridden).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- dat_i  in  8  ingress byte.
- val_i  in  1  ingress byte valid; no backpressure.
- sof_i  in  1  first byte of frame; qualified by val_i.
- eof_i  in  1  last byte of frame; qualified by val_i; may coincide with sof_i.
- cts  in  1  clear-to-send from the cipher stage.
- dat_o  out  8  byte to cipher.
- val_o  out  1  byte valid to cipher.
- sof_o  out  1  first byte of released frame.
- eof_o  out  1  last byte of released frame.
- ovf  out  1  one-cycle pulse: a frame was dropped.
- frm  out  AW+1  number of committed frames waiting.

## Operation
- RAM entries are 9 bits: {eof, dat}. Write pointer wp, committed pointer cp, read pointer rp, all AW+1 bits with wrap bit; used = wp − rp (modulo 2^(AW+1)); full when used == DEPTH.
- Write side state: open flag.
  - val_i & sof_i: if open, current frame aborted (wp ← cp, ovf pulse); then open ← 1, byte written.
  - val_i & ~sof_i & open: byte written.
  - val_i & ~sof_i & ~open: byte ignored, no ovf.
  - Byte with val_i arriving when full: frame dropped (wp ← cp, open ← 0, ovf pulse); remaining bytes of that frame ignored until next sof_i.
  - val_i & eof_i on an accepted byte: cp ← wp+1, open ← 0, frm increments next cycle.
- Read side FSM:
  - IDLE: when frm > 0 and cts == 1 → SEND; cts is sampled only here.
  - SEND: one RAM read per cycle, rp increments; the read of an entry with eof bit set → LAST.
  - LAST: drain final registered byte, frm decrements → IDLE.
- Once SEND entered, the frame is streamed one byte per cycle with val_o continuously high regardless of cts.
- Simultaneous commit and release in one cycle: frm unchanged.
- Frames longer than DEPTH bytes always drop.

## Timing
- Reset: val_o, sof_o, eof_o, ovf = 0; dat_o = 0; frm = 0; wp = cp = rp = 0; open = 0; FSM IDLE. Reset mid-frame discards all stored and partial frames.
- RAM read is registered (1 cycle).
- Latency: with buffer empty, FSM IDLE and cts held 1, first val_o/sof_o appears exactly 3 cycles after the cycle eof_i is accepted (commit +1, FSM start +1, RAM read +1).
- Back-to-back frames: at least one idle cycle (val_o = 0) between eof_o and next sof_o.
- ovf asserts the cycle after the offending input byte, one cycle wide.
- Space freed by reads is usable by writes the following cycle.

## Test plan
- Single 5-byte frame 0x01..0x05, cts = 1 -> val_o 5 consecutive cycles, sof_o with 0x01, eof_o with 0x05, first byte 3 cycles after eof_i; frm 1→0.
- One-byte frame (sof_i = eof_i = 1, 0xAA) -> one output cycle with sof_o = eof_o = 1, dat_o = 0xAA.
- cts = 0 while three frames of 4, 7, 1 bytes arrive -> frm = 3, no val_o; raise cts -> three bursts in order, each separated by ≥1 idle cycle, byte-exact.
- DEPTH = 16, write 10-byte frame then 10-byte frame with cts = 0 -> second frame dropped, ovf one pulse, frm = 1; after release, frame of 16 bytes accepted intact (pointer wrap).
- sof_i at byte 3 of an open frame -> first frame discarded with ovf pulse, second frame delivered intact; stray val_i without sof_i ignored, no ovf.
- Reset asserted mid-SEND -> all outputs 0 next cycle, frm = 0; subsequent frame delivered normally.
